// File: rtl/shr_frame_monitor_pkg.sv
// rtl/shr_frame_monitor_pkg.sv - shared state type and defaults for the frame monitor
package shr_pkg;

  localparam int unsigned MAX_BITS_DEF = 1024;
  localparam int unsigned CNT_W_DEF    = 11;
  localparam logic        SYNC_ACT_DEF = 1'b0;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/shr_frame_monitor_if.sv
// rtl/shr_frame_monitor_if.sv - serial pin loopback and frame result bundle
interface shr_frame_monitor_if #(
  parameter int MAX_BITS = shr_pkg::MAX_BITS_DEF,
  parameter int CNT_W    = shr_pkg::CNT_W_DEF
);

  logic                ser_clk;
  logic                ser_din;
  logic                ser_syn;
  logic [9:0]          exp_length;
  logic [MAX_BITS-1:0] frame_data;
  logic [CNT_W-1:0]    bit_count;
  logic                frame_done;
  logic                len_err;
  logic                ovf;
  logic [15:0]         frame_cnt;
  logic                busy;

  modport master (
    output ser_clk, ser_din, ser_syn, exp_length,
    input  frame_data, bit_count, frame_done, len_err, ovf, frame_cnt, busy
  );

  modport slave (
    input  ser_clk, ser_din, ser_syn, exp_length,
    output frame_data, bit_count, frame_done, len_err, ovf, frame_cnt, busy
  );

endinterface

// File: rtl/shr_frame_monitor_sync_2ff.sv
// rtl/shr_frame_monitor_sync_2ff.sv - single-bit two-flop synchronizer with settable reset level
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/shr_frame_monitor.sv
// rtl/shr_frame_monitor.sv - reassembles looped-back serial frames and checks their length
module shr_frame_monitor
  import shr_pkg::*;
#(
  parameter int   MAX_BITS = MAX_BITS_DEF,
  parameter int   CNT_W    = CNT_W_DEF,
  parameter logic SYNC_ACT = SYNC_ACT_DEF
) (
  input  logic              clk_in,
  input  logic              rst,
  shr_frame_monitor_if.slave mon
);

  localparam int              IDX_W   = $clog2(MAX_BITS);
  localparam logic [CNT_W:0]  CNT_MAX = (CNT_W + 1)'(MAX_BITS);

  logic clk_s, din_s, syn_s;

  // Sync resets to its active level so ARM cannot leave before real pin data arrives
  sync_2ff #(.RST_VAL(1'b0))     u_sync_clk (.clk(clk_in), .rst(rst), .d(mon.ser_clk), .q(clk_s));
  sync_2ff #(.RST_VAL(1'b0))     u_sync_din (.clk(clk_in), .rst(rst), .d(mon.ser_din), .q(din_s));
  sync_2ff #(.RST_VAL(SYNC_ACT)) u_sync_syn (.clk(clk_in), .rst(rst), .d(mon.ser_syn), .q(syn_s));

  logic                clk_prev_q,   clk_prev_d;
  logic                clk_rise_q,   clk_rise_d;
  logic                din_q,        din_d;
  logic                syn_act_q,    syn_act_d;
  state_e              state_q,      state_d;
  logic [CNT_W:0]      cnt_q,        cnt_d;
  logic                ovf_flag_q,   ovf_flag_d;
  logic [MAX_BITS-1:0] frame_data_q, frame_data_d;
  logic [CNT_W-1:0]    bit_count_q,  bit_count_d;
  logic                len_err_q,    len_err_d;
  logic                ovf_q,        ovf_d;
  logic [15:0]         frame_cnt_q,  frame_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q,       busy_d;

  always_comb begin
    clk_prev_d   = clk_s;
    clk_rise_d   = clk_s & ~clk_prev_q;
    din_d        = din_s;
    syn_act_d    = (syn_s == SYNC_ACT);
    state_d      = state_q;
    cnt_d        = cnt_q;
    ovf_flag_d   = ovf_flag_q;
    frame_data_d = frame_data_q;
    bit_count_d  = bit_count_q;
    len_err_d    = len_err_q;
    ovf_d        = ovf_q;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      ST_ARM: begin
        if (!syn_act_q) state_d = ST_IDLE;
      end
      // Level test here also catches a sync that asserted while still in DONE
      ST_IDLE: begin
        if (syn_act_q) begin
          state_d      = ST_CAPTURE;
          cnt_d        = '0;
          ovf_flag_d   = 1'b0;
          frame_data_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (clk_rise_q) begin
          if (cnt_q < CNT_MAX) frame_data_d[cnt_q[IDX_W-1:0]] = din_q;
          else                 ovf_flag_d = 1'b1;
          if (cnt_q <= CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
        if (!syn_act_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        bit_count_d = (cnt_q > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_q[CNT_W-1:0];
        ovf_d       = ovf_flag_q;
        len_err_d   = (cnt_q != {{(CNT_W - 9){1'b0}}, mon.exp_length});
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_ARM;
    endcase

    frame_done_d = (state_d == ST_DONE);
    busy_d       = (state_d == ST_CAPTURE);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      clk_prev_q   <= 1'b0;
      clk_rise_q   <= 1'b0;
      din_q        <= 1'b0;
      syn_act_q    <= 1'b1;
      state_q      <= ST_ARM;
      cnt_q        <= '0;
      ovf_flag_q   <= 1'b0;
      frame_data_q <= '0;
      bit_count_q  <= '0;
      len_err_q    <= 1'b0;
      ovf_q        <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      clk_prev_q   <= clk_prev_d;
      clk_rise_q   <= clk_rise_d;
      din_q        <= din_d;
      syn_act_q    <= syn_act_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ovf_flag_q   <= ovf_flag_d;
      frame_data_q <= frame_data_d;
      bit_count_q  <= bit_count_d;
      len_err_q    <= len_err_d;
      ovf_q        <= ovf_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign mon.frame_data = frame_data_q;
  assign mon.bit_count  = bit_count_q;
  assign mon.frame_done = frame_done_q;
  assign mon.len_err    = len_err_q;
  assign mon.ovf        = ovf_q;
  assign mon.frame_cnt  = frame_cnt_q;
  assign mon.busy       = busy_q;

endmodule

// File: tb/tb_shr_frame_monitor.sv
// tb/tb_shr_frame_monitor.sv - directed frames against a frame-level reference model
module tb_shr_frame_monitor;

  localparam int MAXB = 1024;
  localparam int CW   = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shr_frame_monitor_if #(.MAX_BITS(MAXB), .CNT_W(CW)) ifc ();

  shr_frame_monitor #(.MAX_BITS(MAXB), .CNT_W(CW), .SYNC_ACT(1'b0)) dut (
    .clk_in(clk),
    .rst   (rst),
    .mon   (ifc)
  );

  typedef struct {
    int              n;
    logic [9:0]      exp_len;
    logic [MAXB-1:0] data;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     tx_bits[0:1099];

  int              m_bit_count = 0;
  int              m_len_err   = 0;
  int              m_ovf       = 0;
  int              m_frame_cnt = 0;
  logic [MAXB-1:0] m_data      = '0;
  bit              prev_done   = 1'b0;
  frame_t          cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame-level model: each completed frame reports what was sent, clipped to the buffer
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_bit_count = 0;
      m_len_err   = 0;
      m_ovf       = 0;
      m_frame_cnt = 0;
      m_data      = '0;
      prev_done   = 1'b0;
    end else begin
      if (prev_done) begin
        m_bit_count = (cur.n > MAXB) ? MAXB : cur.n;
        m_ovf       = (cur.n > MAXB) ? 1 : 0;
        m_len_err   = (cur.n != int'(cur.exp_len)) ? 1 : 0;
        m_frame_cnt = (m_frame_cnt + 1) % 65536;
        m_data      = cur.data;
        checks++;
        if (ifc.frame_data !== m_data) begin
          int idx = 0;
          errors++;
          for (int i = MAXB - 1; i >= 0; i--) if (ifc.frame_data[i] !== m_data[i]) idx = i;
          $display("FAIL frame_data: bit %0d got %b expected %b", idx, ifc.frame_data[idx], m_data[idx]);
        end
      end
      prev_done = 1'b0;
      if (ifc.frame_done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_done_expected: got 1 expected 0");
        end else begin
          cur       = exp_q.pop_front();
          prev_done = 1'b1;
        end
      end
      chk("bit_count", 32'(ifc.bit_count), m_bit_count);
      chk("len_err",   32'(ifc.len_err),   m_len_err);
      chk("ovf",       32'(ifc.ovf),       m_ovf);
      chk("frame_cnt", 32'(ifc.frame_cnt), m_frame_cnt);
    end
  end

  task automatic pulse_bit(input bit b);
    ifc.ser_din = b;
    tick(4);
    ifc.ser_clk = 1'b1;
    tick(4);
    ifc.ser_clk = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit coinc, output int lat);
    frame_t r;
    r.n       = n;
    r.exp_len = ifc.exp_length;
    r.data    = '0;
    for (int i = 0; i < n && i < MAXB; i++) r.data[i] = tx_bits[i];
    exp_q.push_back(r);
    ifc.ser_clk = 1'b0;
    ifc.ser_syn = 1'b0;
    tick(8);
    chk("busy_in_frame", 32'(ifc.busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      ifc.ser_din = tx_bits[i];
      tick(4);
      ifc.ser_clk = 1'b1;
      if (coinc && i == n - 1) break;
      tick(4);
      ifc.ser_clk = 1'b0;
    end
    if (!(coinc && n > 0)) tick(4);
    ifc.ser_syn = 1'b1;
    lat = 0;
    while (lat < 30 && ifc.frame_done !== 1'b1) begin
      tick(1);
      lat++;
    end
    chk("frame_done_seen", 32'(lat < 30), 32'd1);
    ifc.ser_clk = 1'b0;
    tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_frame_data"}, 32'(|ifc.frame_data), 32'd0);
    chk({tag, "_bit_count"},  32'(ifc.bit_count),   32'd0);
    chk({tag, "_len_err"},    32'(ifc.len_err),     32'd0);
    chk({tag, "_ovf"},        32'(ifc.ovf),         32'd0);
    chk({tag, "_frame_cnt"},  32'(ifc.frame_cnt),   32'd0);
    chk({tag, "_frame_done"}, 32'(ifc.frame_done),  32'd0);
    chk({tag, "_busy"},       32'(ifc.busy),        32'd0);
  endtask

  initial begin
    int          lat;
    logic [15:0] pat16;
    logic [7:0]  pat8;

    ifc.ser_clk    = 1'b0;
    ifc.ser_din    = 1'b0;
    ifc.ser_syn    = 1'b0;
    ifc.exp_length = 10'd16;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;

    // Sync active out of reset: the partial frame must never be reported
    for (int i = 0; i < 8; i++) pulse_bit(1'b1);
    ifc.ser_syn = 1'b1;
    tick(20);
    chk("armed_frame_cnt", 32'(ifc.frame_cnt), 32'd0);
    chk("armed_busy",      32'(ifc.busy),      32'd0);

    pat16 = 16'hA5C3;
    for (int i = 0; i < 16; i++) tx_bits[i] = pat16[i];
    send_frame(16, 1'b0, lat);
    chk("done_latency", 32'(lat), 32'd4);
    chk("a5c3_data",    32'(ifc.frame_data[15:0]), 32'h0000A5C3);
    chk("a5c3_count",   32'(ifc.bit_count), 32'd16);
    chk("a5c3_len_err", 32'(ifc.len_err),   32'd0);
    chk("a5c3_fcnt",    32'(ifc.frame_cnt), 32'd1);
    chk("done_pulse",   32'(ifc.frame_done), 32'd0);
    chk("idle_busy",    32'(ifc.busy),      32'd0);

    send_frame(15, 1'b0, lat);
    chk("short_count",   32'(ifc.bit_count), 32'd15);
    chk("short_len_err", 32'(ifc.len_err),   32'd1);
    chk("short_data",    32'(ifc.frame_data[15:0]), 32'h000025C3);

    send_frame(0, 1'b0, lat);
    chk("zero_count",   32'(ifc.bit_count), 32'd0);
    chk("zero_len_err", 32'(ifc.len_err),   32'd1);
    ifc.exp_length = 10'd0;
    send_frame(0, 1'b0, lat);
    chk("zero_exp0_len_err", 32'(ifc.len_err), 32'd0);

    ifc.exp_length = 10'd8;
    pat8 = 8'h96;
    for (int i = 0; i < 8; i++) tx_bits[i] = pat8[i];
    send_frame(8, 1'b1, lat);
    chk("coinc_count",   32'(ifc.bit_count), 32'd8);
    chk("coinc_len_err", 32'(ifc.len_err),   32'd0);
    chk("coinc_data",    32'(ifc.frame_data[7:0]), 32'h00000096);

    ifc.exp_length = 10'd16;
    for (int i = 0; i < 1030; i++) tx_bits[i] = bit'(((i * 37) >> 2) & 1);
    send_frame(1030, 1'b0, lat);
    chk("ovf_count",   32'(ifc.bit_count), 32'd1024);
    chk("ovf_flag",    32'(ifc.ovf),       32'd1);
    chk("ovf_last",    32'(ifc.frame_data[1023]), 32'(tx_bits[1023]));
    chk("ovf_fcnt",    32'(ifc.frame_cnt), 32'd6);

    for (int i = 0; i < 16; i++) tx_bits[i] = pat16[i];
    send_frame(16, 1'b0, lat);
    chk("post_ovf_flag", 32'(ifc.ovf),     32'd0);
    chk("post_ovf_err",  32'(ifc.len_err), 32'd0);

    // Reset in the middle of a frame, then finish the frame after release
    ifc.ser_syn = 1'b0;
    tick(8);
    for (int i = 0; i < 5; i++) pulse_bit(1'b1);
    ifc.ser_din = 1'b1;
    tick(2);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) pulse_bit(1'b0);
    ifc.ser_syn = 1'b1;
    tick(20);
    chk("midrst_fcnt", 32'(ifc.frame_cnt), 32'd0);

    send_frame(16, 1'b0, lat);
    chk("recover_count", 32'(ifc.bit_count), 32'd16);
    chk("recover_fcnt",  32'(ifc.frame_cnt), 32'd1);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
